// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: packs LANES show-ahead bytes into one word on a
// valid/ready stream, flushing a partial word after TIMEOUT idle cycles.

module fifo_rd_packer_lane #(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             wr,
  input  logic [DSIZE-1:0] din,
  input  logic             keep,
  output logic [DSIZE-1:0] out_byte
);
  logic [DSIZE-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (wr) acc_d = din;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) acc_q <= '0;
    else         acc_q <= acc_d;
  end

  // Unfilled lanes still hold stale bytes from earlier words; mask them out.
  assign out_byte = keep ? acc_q : '0;
endmodule

module fifo_rd_packer #(
  parameter int DSIZE   = 8,
  parameter int LANES   = 2,
  parameter int TIMEOUT = 8
) (
  input  logic                   rclk,
  input  logic                   rrst_n,
  input  logic                   rempty,
  input  logic [DSIZE-1:0]       rdata,
  output logic                   rinc,
  output logic [DSIZE*LANES-1:0] out_data,
  output logic [LANES-1:0]       out_keep,
  output logic                   out_valid,
  input  logic                   out_ready
);
  localparam int              CW   = $clog2(LANES + 1);
  localparam logic [CW-1:0]   FULL = CW'(LANES);
  localparam logic [7:0]      TMO  = 8'(TIMEOUT);

  logic [CW-1:0]                 acc_cnt_q, acc_cnt_d;
  logic [DSIZE*LANES-1:0]        out_data_q, out_data_d;
  logic [LANES-1:0]              out_keep_q, out_keep_d;
  logic                          out_valid_q, out_valid_d;
  logic [7:0]                    idle_q, idle_d;
  logic                          run_q, run_d;

  logic                          slot_free, full, tmo, load, pop;
  logic [CW-1:0]                 wr_idx;
  logic [LANES-1:0]              lane_wr, lane_keep;
  logic [LANES-1:0][DSIZE-1:0]   lane_out;

  genvar i;
  generate
    for (i = 0; i < LANES; i++) begin : g_lane
      assign lane_wr[i]   = pop && (wr_idx == CW'(i));
      assign lane_keep[i] = acc_cnt_q > CW'(i);
      fifo_rd_packer_lane #(.DSIZE(DSIZE)) u_lane (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .wr       (lane_wr[i]),
        .din      (rdata),
        .keep     (lane_keep[i]),
        .out_byte (lane_out[i])
      );
    end
  endgenerate

  always_comb begin
    slot_free = !out_valid_q | out_ready;
    full      = (acc_cnt_q == FULL);
    tmo       = (TIMEOUT != 0) && (acc_cnt_q != '0) && (idle_q == TMO);
    load      = slot_free & (full | tmo);
    // rrst_n is gated in so the pop strobe drops the instant reset asserts.
    rinc      = run_q & rrst_n & !rempty & (!full | load);
    pop       = rinc;
    wr_idx    = load ? '0 : acc_cnt_q;

    run_d       = 1'b1;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_valid_d = out_valid_q;
    acc_cnt_d   = acc_cnt_q;
    idle_d      = idle_q;

    if (load) begin
      out_data_d  = lane_out;
      out_keep_d  = lane_keep;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (load && pop)  acc_cnt_d = CW'(1);
    else if (load)    acc_cnt_d = '0;
    else if (pop)     acc_cnt_d = acc_cnt_q + CW'(1);

    if (pop || load || acc_cnt_q == '0) idle_d = '0;
    else if (idle_q < TMO)              idle_d = idle_q + 8'd1;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      run_q       <= 1'b0;
      acc_cnt_q   <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_valid_q <= 1'b0;
      idle_q      <= '0;
    end else begin
      run_q       <= run_d;
      acc_cnt_q   <= acc_cnt_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_valid_q <= out_valid_d;
      idle_q      <= idle_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer (DSIZE=8, LANES=2, TIMEOUT=8).

module tb_fifo_rd_packer;
  logic        rclk = 1'b0;
  logic        rrst_n;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc;
  logic [15:0] out_data;
  logic [1:0]  out_keep;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  fifo_rd_packer #(.DSIZE(8), .LANES(2), .TIMEOUT(8)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive just after a rising edge, then stop at the following falling edge.
  task automatic step(input logic emp, input logic [7:0] d, input logic rdy);
    @(posedge rclk); #1;
    rempty = emp; rdata = d; out_ready = rdy;
    @(negedge rclk);
  endtask

  task automatic do_reset();
    @(posedge rclk); #1;
    rrst_n = 1'b0; rempty = 1'b1; rdata = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge rclk);
    #1 rrst_n = 1'b1;
    @(posedge rclk);
    @(negedge rclk);
  endtask

  initial begin
    rrst_n = 1'b0; rempty = 1'b0; rdata = 8'h5A; out_ready = 1'b1;

    // reset held with a non-empty FIFO
    for (int k = 0; k < 3; k++) begin
      @(negedge rclk);
      chk("rst_rinc",  32'(rinc),      32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_data",  32'(out_data),  32'h0);
      chk("rst_keep",  32'(out_keep),  32'h0);
    end
    @(posedge rclk); #1 rrst_n = 1'b1;
    @(negedge rclk);
    chk("rel_rinc_e0", 32'(rinc), 32'h0);
    step(1'b0, 8'h5A, 1'b1);
    chk("rel_rinc_e1", 32'(rinc), 32'h1);
    chk("rel_valid",   32'(out_valid), 32'h0);

    // streaming with out_ready=1
    do_reset();
    step(1'b0, 8'h11, 1'b1); chk("st_rinc0", 32'(rinc), 32'h1);
    step(1'b0, 8'h22, 1'b1); chk("st_rinc1", 32'(rinc), 32'h1);
    step(1'b0, 8'h33, 1'b1); chk("st_rinc2", 32'(rinc), 32'h1);
    chk("st_nv0", 32'(out_valid), 32'h0);
    step(1'b0, 8'h44, 1'b1); chk("st_rinc3", 32'(rinc), 32'h1);
    chk("st_v1",  32'(out_valid), 32'h1);
    chk("st_d1",  32'(out_data),  32'h2211);
    chk("st_k1",  32'(out_keep),  32'h3);
    step(1'b1, 8'h00, 1'b1);
    chk("st_gap",  32'(out_valid), 32'h0);
    chk("st_rinc4", 32'(rinc), 32'h0);
    step(1'b1, 8'h00, 1'b1);
    chk("st_v2",  32'(out_valid), 32'h1);
    chk("st_d2",  32'(out_data),  32'h4433);
    chk("st_k2",  32'(out_keep),  32'h3);
    step(1'b1, 8'h00, 1'b1);
    chk("st_ret", 32'(out_valid), 32'h0);

    // backpressure after the first word
    step(1'b0, 8'h11, 1'b1);
    step(1'b0, 8'h22, 1'b1);
    step(1'b0, 8'h33, 1'b1);
    step(1'b0, 8'h44, 1'b0);
    chk("bp_v1",   32'(out_valid), 32'h1);
    chk("bp_d1",   32'(out_data),  32'h2211);
    chk("bp_rinc", 32'(rinc),      32'h1);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 8'h55, 1'b0);
      chk("bp_stall_rinc", 32'(rinc),      32'h0);
      chk("bp_hold_v",     32'(out_valid), 32'h1);
      chk("bp_hold_d",     32'(out_data),  32'h2211);
      chk("bp_hold_k",     32'(out_keep),  32'h3);
    end
    step(1'b1, 8'h00, 1'b1);
    step(1'b1, 8'h00, 1'b1);
    chk("bp_v2", 32'(out_valid), 32'h1);
    chk("bp_d2", 32'(out_data),  32'h4433);
    chk("bp_k2", 32'(out_keep),  32'h3);
    step(1'b1, 8'h00, 1'b0);
    chk("bp_ret", 32'(out_valid), 32'h0);

    // lone byte is flushed TIMEOUT+1 edges after its pop
    step(1'b0, 8'hA5, 1'b1);
    chk("fl_rinc", 32'(rinc), 32'h1);
    for (int k = 0; k < 9; k++) begin
      step(1'b1, 8'h00, 1'b1);
      chk("fl_wait", 32'(out_valid), 32'h0);
    end
    step(1'b1, 8'h00, 1'b1);
    chk("fl_v", 32'(out_valid), 32'h1);
    chk("fl_d", 32'(out_data),  32'h00A5);
    chk("fl_k", 32'(out_keep),  32'h1);
    step(1'b1, 8'h00, 1'b1);
    chk("fl_ret", 32'(out_valid), 32'h0);

    // second byte arrives one cycle before the flush would fire
    step(1'b0, 8'hA5, 1'b1);
    for (int k = 0; k < 7; k++) begin
      step(1'b1, 8'h00, 1'b1);
      chk("nf_wait", 32'(out_valid), 32'h0);
    end
    step(1'b0, 8'hB6, 1'b1);
    chk("nf_rinc", 32'(rinc), 32'h1);
    chk("nf_nv",   32'(out_valid), 32'h0);
    step(1'b1, 8'h00, 1'b1);
    chk("nf_nv2",  32'(out_valid), 32'h0);
    step(1'b1, 8'h00, 1'b1);
    chk("nf_v", 32'(out_valid), 32'h1);
    chk("nf_d", 32'(out_data),  32'hB6A5);
    chk("nf_k", 32'(out_keep),  32'h3);
    step(1'b1, 8'h00, 1'b1);
    chk("nf_ret", 32'(out_valid), 32'h0);

    // mid-operation reset discards held word and partial byte
    step(1'b0, 8'h11, 1'b0);
    step(1'b0, 8'h22, 1'b0);
    step(1'b0, 8'h77, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    chk("mr_pre_v", 32'(out_valid), 32'h1);
    chk("mr_pre_d", 32'(out_data),  32'h2211);
    rempty = 1'b0; rdata = 8'h01;
    rrst_n = 1'b0;
    #1;
    chk("mr_rinc",  32'(rinc),      32'h0);
    chk("mr_valid", 32'(out_valid), 32'h0);
    chk("mr_data",  32'(out_data),  32'h0);
    chk("mr_keep",  32'(out_keep),  32'h0);
    #3 rrst_n = 1'b1;
    step(1'b0, 8'h01, 1'b1);
    chk("mr_rinc1", 32'(rinc), 32'h1);
    step(1'b0, 8'h02, 1'b1);
    chk("mr_rinc2", 32'(rinc), 32'h1);
    step(1'b1, 8'h00, 1'b1);
    chk("mr_nv", 32'(out_valid), 32'h0);
    step(1'b1, 8'h00, 1'b1);
    chk("mr_v", 32'(out_valid), 32'h1);
    chk("mr_d", 32'(out_data),  32'h0201);
    chk("mr_k", 32'(out_keep),  32'h3);
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 8'h00, 1'b1);
      chk("mr_no77", 32'(out_valid), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
